// File: rtl/physics_scheduler_pkg.sv
// Shared types and constants for the physics frame scheduler.
//   sched_state_t : frame sequencer states (IDLE, STEP, LATCH, WAIT)
//   N_PART_DEF    : default particle count
//   COORD_W       : width of signed coordinate / impulse values
//   IMPULSE_DEF   : default button impulse magnitude
//   axis_impulse  : signed impulse for one axis from a +/- button pair
package physics_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        STEP  = 2'd1,
        LATCH = 2'd2,
        WAIT  = 2'd3
    } sched_state_t;

    localparam int N_PART_DEF  = 4;
    localparam int COORD_W     = 16;
    localparam int IMPULSE_DEF = 16;

    // Opposing buttons cancel to zero.
    function automatic logic signed [COORD_W-1:0] axis_impulse(
        input logic                      pos,
        input logic                      neg,
        input logic signed [COORD_W-1:0] mag
    );
        logic signed [COORD_W-1:0] acc;
        acc = '0;
        if (pos) acc = acc + mag;
        if (neg) acc = acc - mag;
        return acc;
    endfunction

endpackage

// File: rtl/physics_scheduler_if.sv
// Particle-side bus of the frame scheduler.
//   step_req    : one-hot request, particle i performs one update
//   step_done   : per-particle completion
//   frame_latch : one-cycle pulse, render block captures the matrix
//   impulse_x/y : signed per-frame impulse shared by all particles
// Modports: master = scheduler, slave = particle/render side.
interface physics_scheduler_if #(
    parameter int N_PART = physics_pkg::N_PART_DEF
);
    logic [N_PART-1:0]                      step_req;
    logic [N_PART-1:0]                      step_done;
    logic                                   frame_latch;
    logic signed [physics_pkg::COORD_W-1:0] impulse_x;
    logic signed [physics_pkg::COORD_W-1:0] impulse_y;

    modport master (
        output step_req, frame_latch, impulse_x, impulse_y,
        input  step_done
    );

    modport slave (
        input  step_req, frame_latch, impulse_x, impulse_y,
        output step_done
    );
endinterface

// File: rtl/physics_scheduler_button_conditioner.sv
// Button conditioner: two-flop synchroniser followed by a sticky pending flag.
//   clk, reset_n : clock, asynchronous active-low reset
//   btn          : raw asynchronous button, active-high
//   clear        : frame sample edge; pending restarts from the current sync value
//   pending      : sticky "pressed since last sample" flag
module button_conditioner (
    input  logic clk,
    input  logic reset_n,
    input  logic btn,
    input  logic clear,
    output logic pending
);
    logic sync1_q, sync2_q, pending_q;
    logic pending_d;

    // A press seen on the clearing edge itself is kept so it lands in the next frame.
    always_comb begin
        pending_d = clear ? sync2_q : (pending_q | sync2_q);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            sync1_q   <= btn;
            sync2_q   <= sync1_q;
            pending_q <= pending_d;
        end
    end

    assign pending = pending_q;
endmodule

// File: rtl/physics_scheduler.sv
// Frame sequencer for the soft-body physics datapath. Steps each particle in
// turn, pulses the matrix latch, idles WAIT_CYCLES, then starts the next frame.
// Buttons are conditioned into a per-frame signed impulse.
//   clk, reset_n     : clock, asynchronous active-low reset
//   run              : 1 = frames run continuously, 0 = stop at the next WAIT exit
//   btn_left/right/up/down : raw asynchronous buttons
//   step_frame       : only with PHYS_SINGLE_STEP_EN; WAIT exit also needs step_frame=1
//   bus (master)     : step_req/step_done, frame_latch, impulse_x/y
//   frame_count      : completed frames (wraps)
//   busy             : 1 whenever not IDLE
//   timeout_err      : sticky, a particle exceeded STEP_TIMEOUT
// Optional feature macro: PHYS_SINGLE_STEP_EN.
module physics_scheduler
    import physics_pkg::*;
#(
    parameter int N_PART       = N_PART_DEF,
    parameter int WAIT_CYCLES  = 10000,
    parameter int STEP_TIMEOUT = 255,
    parameter int IMPULSE      = IMPULSE_DEF
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                run,
    input  logic                btn_left,
    input  logic                btn_right,
    input  logic                btn_up,
    input  logic                btn_down,
`ifdef PHYS_SINGLE_STEP_EN
    input  logic                step_frame,
`endif
    physics_scheduler_if.master bus,
    output logic [15:0]         frame_count,
    output logic                busy,
    output logic                timeout_err
);
    localparam int IDX_W  = (N_PART > 1) ? $clog2(N_PART) : 1;
    localparam int TMR_W  = $clog2(STEP_TIMEOUT + 1);
    localparam int WAIT_W = $clog2(WAIT_CYCLES + 1);
    localparam logic signed [COORD_W-1:0] IMP_MAG = COORD_W'(IMPULSE);

    // Button index order: 0=left, 1=right, 2=up, 3=down.
    logic [3:0] btn_raw;
    logic [3:0] pending;
    logic       start_frame;
    logic       step_go;

    assign btn_raw = {btn_down, btn_up, btn_right, btn_left};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_btn
            button_conditioner u_cond (
                .clk     (clk),
                .reset_n (reset_n),
                .btn     (btn_raw[gi]),
                .clear   (start_frame),
                .pending (pending[gi])
            );
        end
    endgenerate

`ifdef PHYS_SINGLE_STEP_EN
    assign step_go = step_frame;
`else
    assign step_go = 1'b1;
`endif

    sched_state_t              state_q, state_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [TMR_W-1:0]          timer_q, timer_d;
    logic [WAIT_W-1:0]         wait_q, wait_d;
    logic [N_PART-1:0]         step_req_q, step_req_d;
    logic                      frame_latch_q, frame_latch_d;
    logic [15:0]               frame_count_q, frame_count_d;
    logic                      busy_q, busy_d;
    logic                      timeout_err_q, timeout_err_d;
    logic signed [COORD_W-1:0] impulse_x_q, impulse_x_d;
    logic signed [COORD_W-1:0] impulse_y_q, impulse_y_d;

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        timer_d       = timer_q;
        wait_d        = wait_q;
        step_req_d    = step_req_q;
        frame_latch_d = 1'b0;
        frame_count_d = frame_count_q;
        timeout_err_d = timeout_err_q;
        impulse_x_d   = impulse_x_q;
        impulse_y_d   = impulse_y_q;
        start_frame   = 1'b0;

        case (state_q)
            IDLE: begin
                if (run) start_frame = 1'b1;
            end
            STEP: begin
                if (bus.step_done[idx_q] || timer_q == TMR_W'(STEP_TIMEOUT)) begin
                    // A real completion on the timeout cycle is not an error.
                    if (!bus.step_done[idx_q]) timeout_err_d = 1'b1;
                    timer_d = '0;
                    if (idx_q == IDX_W'(N_PART - 1)) begin
                        state_d       = LATCH;
                        step_req_d    = '0;
                        frame_latch_d = 1'b1;
                        frame_count_d = frame_count_q + 16'd1;
                    end else begin
                        idx_d      = idx_q + IDX_W'(1);
                        step_req_d = step_req_q << 1;
                    end
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            LATCH: begin
                state_d = WAIT;
                wait_d  = WAIT_W'(WAIT_CYCLES - 1);
            end
            WAIT: begin
                if (wait_q != '0) begin
                    wait_d = wait_q - WAIT_W'(1);
                end else if (!run) begin
                    state_d = IDLE;
                end else if (step_go) begin
                    start_frame = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Impulse is sampled on the same edge the pending flags are cleared.
        if (start_frame) begin
            state_d     = STEP;
            idx_d       = '0;
            timer_d     = '0;
            step_req_d  = N_PART'(1);
            impulse_x_d = axis_impulse(pending[1], pending[0], IMP_MAG);
            impulse_y_d = axis_impulse(pending[3], pending[2], IMP_MAG);
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            timer_q       <= '0;
            wait_q        <= '0;
            step_req_q    <= '0;
            frame_latch_q <= 1'b0;
            frame_count_q <= '0;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b0;
            impulse_x_q   <= '0;
            impulse_y_q   <= '0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            timer_q       <= timer_d;
            wait_q        <= wait_d;
            step_req_q    <= step_req_d;
            frame_latch_q <= frame_latch_d;
            frame_count_q <= frame_count_d;
            busy_q        <= busy_d;
            timeout_err_q <= timeout_err_d;
            impulse_x_q   <= impulse_x_d;
            impulse_y_q   <= impulse_y_d;
        end
    end

    assign bus.step_req    = step_req_q;
    assign bus.frame_latch = frame_latch_q;
    assign bus.impulse_x   = impulse_x_q;
    assign bus.impulse_y   = impulse_y_q;
    assign frame_count     = frame_count_q;
    assign busy            = busy_q;
    assign timeout_err     = timeout_err_q;
endmodule

// File: tb/tb_physics_scheduler.sv
// Scoreboard bench for physics_scheduler (N_PART=4, WAIT_CYCLES=4, STEP_TIMEOUT=3).
// Stimulus pushes expected step_req values and per-frame records; a monitor
// pops and compares on each new step request and each frame_latch pulse.
module tb_physics_scheduler;
    import physics_pkg::*;

    localparam int NP = 4;
    localparam int WC = 4;
    localparam int ST = 3;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic run = 1'b0;
    logic btn_left = 1'b0, btn_right = 1'b0, btn_up = 1'b0, btn_down = 1'b0;
`ifdef PHYS_SINGLE_STEP_EN
    logic step_frame = 1'b1;
`endif
    logic [NP-1:0] stuck_mask = '0;
    logic [15:0]   frame_count;
    logic          busy, timeout_err;

    physics_scheduler_if #(.N_PART(NP)) bus();

    physics_scheduler #(
        .N_PART(NP), .WAIT_CYCLES(WC), .STEP_TIMEOUT(ST), .IMPULSE(16)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .run         (run),
        .btn_left    (btn_left),
        .btn_right   (btn_right),
        .btn_up      (btn_up),
        .btn_down    (btn_down),
`ifdef PHYS_SINGLE_STEP_EN
        .step_frame  (step_frame),
`endif
        .bus         (bus),
        .frame_count (frame_count),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    // Particle model: completion echoes the request one cycle later, unless stuck.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) bus.step_done <= '0;
        else          bus.step_done <= bus.step_req & ~stuck_mask;
    end

    longint cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    typedef struct {
        logic [15:0]        count;
        logic signed [15:0] ix;
        logic signed [15:0] iy;
        logic               terr;
        int                 period;   // 0 = no previous latch to measure from
    } frame_t;

    logic [NP-1:0] exp_step[$];
    frame_t        exp_frame[$];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_frame(input logic [15:0] count, input logic signed [15:0] ix,
                              input logic signed [15:0] iy, input logic terr, input int period);
        frame_t f;
        for (int i = 0; i < NP; i++) exp_step.push_back(NP'(1) << i);
        f.count = count; f.ix = ix; f.iy = iy; f.terr = terr; f.period = period;
        exp_frame.push_back(f);
    endtask

    task automatic wait_req(input logic [NP-1:0] v, input string tag);
        int n = 0;
        while (bus.step_req !== v && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++; errors++;
            $display("FAIL %s timeout: step_req %b required %b", tag, bus.step_req, v);
        end
    endtask

    task automatic wait_latch(input string tag);
        int n = 0;
        while (bus.frame_latch !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++; errors++;
            $display("FAIL %s timeout: frame_latch %b required 1", tag, bus.frame_latch);
        end
        @(negedge clk);
    endtask

    // Monitor / scoreboard
    initial begin
        logic [NP-1:0] prev_req = '0;
        logic          prev_latch = 1'b0;
        longint        last_latch = 0;
        logic [NP-1:0] e;
        frame_t        f;
        forever begin
            @(negedge clk);
            if (reset_n) begin
                if (bus.step_req != prev_req && bus.step_req != '0) begin
                    if (exp_step.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL step_req: got %b expected no request", bus.step_req);
                    end else begin
                        e = exp_step.pop_front();
                        check("step_req", 32'(bus.step_req), 32'(e));
                        $display("step_req %b at cycle %0d", bus.step_req, cyc);
                    end
                end
                if (prev_latch) check("frame_latch_width", 32'(bus.frame_latch), 32'd0);
                if (bus.frame_latch && !prev_latch) begin
                    if (exp_frame.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL frame_latch: got pulse expected none");
                    end else begin
                        f = exp_frame.pop_front();
                        check("frame_count", 32'(frame_count), 32'(f.count));
                        check("impulse_x", 32'(bus.impulse_x), 32'(f.ix));
                        check("impulse_y", 32'(bus.impulse_y), 32'(f.iy));
                        check("timeout_err", 32'(timeout_err), 32'(f.terr));
                        if (f.period != 0) check("frame_period", 32'(cyc - last_latch), 32'(f.period));
                        $display("frame %0d latched at cycle %0d ix=%0d iy=%0d terr=%0b",
                                 frame_count, cyc, bus.impulse_x, bus.impulse_y, timeout_err);
                    end
                    last_latch = cyc;
                end
            end
            prev_req   = bus.step_req;
            prev_latch = bus.frame_latch;
        end
    end

    // Stimulus
    initial begin
        repeat (2) @(negedge clk);
        check("rst_step_req", 32'(bus.step_req), 32'd0);
        check("rst_frame_latch", 32'(bus.frame_latch), 32'd0);
        check("rst_frame_count", 32'(frame_count), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_timeout_err", 32'(timeout_err), 32'd0);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_step_req", 32'(bus.step_req), 32'd0);

        // Frame 1: plain frame; a left tap during it shapes frame 2.
        push_frame(16'd1, 16'sd0, 16'sd0, 1'b0, 0);
        run = 1'b1;
        wait_req(4'b0010, "f1_req1");
        btn_left = 1'b1;
        @(negedge clk);
        btn_left = 1'b0;
        push_frame(16'd2, -16'sd16, 16'sd0, 1'b0, 13);
        wait_latch("f1_latch");

        // Frame 2: left+right cancel, down gives +16 on y, seen in frame 3.
        wait_req(4'b0010, "f2_req1");
        btn_left = 1'b1; btn_right = 1'b1; btn_down = 1'b1;
        @(negedge clk);
        btn_left = 1'b0; btn_right = 1'b0; btn_down = 1'b0;
        push_frame(16'd3, 16'sd0, 16'sd16, 1'b0, 13);
        wait_latch("f2_latch");

        // Frame 4: particle 2 never completes -> 4-cycle hold, timeout flagged.
        push_frame(16'd4, 16'sd0, 16'sd0, 1'b1, 15);
        wait_latch("f3_latch");
        check("terr_before_stuck", 32'(timeout_err), 32'd0);
        stuck_mask = 4'b0100;
        wait_latch("f4_latch");
        stuck_mask = '0;

        // Frame 5: run drops at idx 1; frame still latches, then IDLE after WAIT.
        push_frame(16'd5, 16'sd0, 16'sd0, 1'b1, 13);
        wait_req(4'b0010, "f5_req1");
        run = 1'b0;
        wait_latch("f5_latch");
        repeat (3) @(negedge clk);
        check("busy_last_wait", 32'(busy), 32'd1);
        @(negedge clk);
        check("busy_after_stop", 32'(busy), 32'd0);
        repeat (10) @(negedge clk);
        check("stopped_step_req", 32'(bus.step_req), 32'd0);
        check("stopped_frame_count", 32'(frame_count), 32'd5);
        check("sticky_timeout_err", 32'(timeout_err), 32'd1);

`ifdef PHYS_SINGLE_STEP_EN
        step_frame = 1'b0;
        run = 1'b1;
        push_frame(16'd6, 16'sd0, 16'sd0, 1'b1, 0);
        wait_latch("f6_latch");
        repeat (6) @(negedge clk);
        check("hold_busy", 32'(busy), 32'd1);
        check("hold_step_req", 32'(bus.step_req), 32'd0);
        exp_step.push_back(NP'(1));
        step_frame = 1'b1;
        @(negedge clk);
        check("single_step_req", 32'(bus.step_req), 32'd1);
`else
        exp_step.push_back(NP'(1));
        run = 1'b1;
        wait_req(4'b0001, "restart_req0");
`endif

        // Reset while step_req=0001: outputs clear without a clock edge.
        reset_n = 1'b0;
        #1;
        check("midrst_step_req", 32'(bus.step_req), 32'd0);
        check("midrst_frame_count", 32'(frame_count), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_timeout_err", 32'(timeout_err), 32'd0);
        check("midrst_impulse_x", 32'(bus.impulse_x), 32'd0);
        run = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_busy", 32'(busy), 32'd0);
        check("post_rst_step_req", 32'(bus.step_req), 32'd0);

        check("step_queue_empty", 32'(exp_step.size()), 32'd0);
        check("frame_queue_empty", 32'(exp_frame.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
